// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision divider.
package fp_pkg;
  localparam int WIDTH      = 32;
  localparam int EXP_WIDTH  = 8;
  localparam int MANT_WIDTH = 23;
  localparam int BIAS       = 127;

  localparam logic [WIDTH-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORMALIZE, ROUND, DONE} div_state_t;
endpackage

// File: rtl/fp_classify.sv
// Splits an IEEE-754 single into sign, exponent, hidden-one mantissa and class.
// Denormals are reported as ZERO with a cleared mantissa.
module fp_classify import fp_pkg::*; (
  input  logic [WIDTH-1:0]    op,
  output logic                sign,
  output logic [EXP_WIDTH-1:0] expo,
  output logic [MANT_WIDTH:0] mant,
  output fp_class_t           cls
);
  logic [EXP_WIDTH-1:0]  e;
  logic [MANT_WIDTH-1:0] f;

  assign sign = op[WIDTH-1];
  assign e    = op[WIDTH-2 -: EXP_WIDTH];
  assign f    = op[MANT_WIDTH-1:0];
  assign expo = e;
  assign mant = (e == '0) ? '0 : {1'b1, f};

  always_comb begin
    cls = NORMAL;
    if (e == '0)
      cls = ZERO;
    else if (e == '1)
      cls = (f == '0) ? INF : NAN;
  end
endmodule

// File: rtl/floating_point_divider.sv
// Multi-cycle IEEE-754 single-precision divider using restoring division.
// Define FPDIV_ROUND_EN for round-to-nearest-even; otherwise the quotient truncates.
module floating_point_divider #(
  parameter int WIDTH      = fp_pkg::WIDTH,
  parameter int EXP_WIDTH  = fp_pkg::EXP_WIDTH,
  parameter int MANT_WIDTH = fp_pkg::MANT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  import fp_pkg::*;

  localparam int SIG_W = MANT_WIDTH + 1;
  localparam int Q_W   = MANT_WIDTH + 3;
  localparam int R_W   = SIG_W + 2;
  localparam int E_W   = EXP_WIDTH + 2;
  localparam int CNT_W = $clog2(Q_W + 1);
  localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(Q_W - 1);
  localparam logic signed [E_W-1:0] BIAS_S    = E_W'(BIAS);
  localparam logic signed [E_W-1:0] ONE_S     = E_W'(1);
  localparam logic signed [E_W-1:0] ZERO_S    = E_W'(0);
  localparam logic signed [E_W-1:0] EXP_MAX   = E_W'((1 << EXP_WIDTH) - 1);

`ifdef FPDIV_ROUND_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  div_state_t                state;
  logic [WIDTH-1:0]          a_q, b_q;
  logic                      sign_q, sticky_q;
  logic signed [E_W-1:0]     exp_q;
  logic [SIG_W-1:0]          divisor_q;
  logic [R_W-1:0]            rem_q;
  logic [Q_W-1:0]            quo_q;
  logic [CNT_W-1:0]          cnt_q;
  fp_flags_t                 flags_q;

  logic                      sign_a, sign_b, sgn;
  logic [EXP_WIDTH-1:0]      exp_a, exp_b;
  logic [SIG_W-1:0]          mant_a, mant_b;
  fp_class_t                 cls_a, cls_b;

  fp_classify u_cls_a (.op(a_q), .sign(sign_a), .expo(exp_a), .mant(mant_a), .cls(cls_a));
  fp_classify u_cls_b (.op(b_q), .sign(sign_b), .expo(exp_b), .mant(mant_b), .cls(cls_b));

  assign sgn   = sign_a ^ sign_b;
  assign flags = flags_q;

  function automatic logic [SIG_W:0] round_mant(input logic [SIG_W-1:0] m, input logic g,
                                                input logic r, input logic s);
    logic up;
    up = RNE_EN && g && (r || s || m[0]);
    return {1'b0, m} + {{SIG_W{1'b0}}, up};
  endfunction

  // Operand unpack: special-case decode and biased exponent difference
  logic                  special;
  logic [WIDTH-1:0]      sp_result;
  fp_flags_t             sp_flags;
  logic signed [E_W-1:0] ea_s, eb_s, exp_diff;

  assign ea_s     = {2'b00, exp_a};
  assign eb_s     = {2'b00, exp_b};
  assign exp_diff = ea_s - eb_s + BIAS_S;

  always_comb begin
    special   = 1'b1;
    sp_result = '0;
    sp_flags  = '0;
    if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == ZERO) ||
        (cls_a == INF && cls_b == INF)) begin
      sp_result        = QNAN;
      sp_flags.invalid = 1'b1;
    end else if (cls_a == INF) begin
      sp_result = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else if (cls_b == ZERO) begin
      sp_result            = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      sp_flags.div_by_zero = 1'b1;
    end else if (cls_a == ZERO || cls_b == INF) begin
      sp_result = {sgn, {(WIDTH-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Restoring division step
  logic           rem_ge;
  logic [R_W-1:0] rem_sub, rem_next;

  assign rem_ge   = rem_q >= {2'b00, divisor_q};
  assign rem_sub  = rem_ge ? rem_q - {2'b00, divisor_q} : rem_q;
  assign rem_next = rem_sub << 1;

  // Rounding and range check on the normalized quotient
  logic [SIG_W:0]        rounded;
  logic signed [E_W-1:0] exp_r;
  logic [MANT_WIDTH-1:0] frac_r;
  logic [WIDTH-1:0]      rnd_result;
  fp_flags_t             rnd_flags;

  always_comb begin
    rounded    = round_mant(quo_q[Q_W-1:2], quo_q[1], quo_q[0], sticky_q);
    exp_r      = rounded[SIG_W] ? exp_q + ONE_S : exp_q;
    frac_r     = rounded[SIG_W] ? rounded[MANT_WIDTH:1] : rounded[MANT_WIDTH-1:0];
    rnd_result = '0;
    rnd_flags  = '0;
    if (!exp_r[E_W-1] && exp_r >= EXP_MAX) begin
      rnd_result         = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      rnd_flags.overflow = 1'b1;
    end else if (exp_r[E_W-1] || exp_r == ZERO_S) begin
      rnd_result          = {sign_q, {(WIDTH-1){1'b0}}};
      rnd_flags.underflow = 1'b1;
    end else begin
      rnd_result = {sign_q, exp_r[EXP_WIDTH-1:0], frac_r};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      sticky_q  <= 1'b0;
      exp_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q    <= sgn;
          exp_q     <= exp_diff;
          divisor_q <= mant_b;
          rem_q     <= {2'b00, mant_a};
          quo_q     <= '0;
          cnt_q     <= '0;
          if (special) begin
            result  <= sp_result;
            flags_q <= sp_flags;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[Q_W-2:0], rem_ge};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER)
            state <= NORMALIZE;
        end
        NORMALIZE: begin
          // Quotient lies in (0.5, 2): at most one leading zero to remove
          if (!quo_q[Q_W-1]) begin
            quo_q <= quo_q << 1;
            exp_q <= exp_q - ONE_S;
          end
          sticky_q <= |rem_q;
          state    <= ROUND;
        end
        ROUND: begin
          result  <= rnd_result;
          flags_q <= rnd_flags;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_floating_point_divider.sv
// Scoreboard bench: driver pushes expected results, negedge monitor pops on done.
module tb_floating_point_divider;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  flags;

  floating_point_divider dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          done_at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  int          busy_from = 0;
  int          busy_until = -1;
  int          busy_bad = 0;
  int          hold_bad = 0;
  logic [31:0] last_res = '0;
  logic [3:0]  last_flg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  function automatic int fclass(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0;
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'h0) ? 2 : 3;
    return 1;
  endfunction

  // Reference: classify, then one exact integer division of the significands
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f);
    int cx, cy, e;
    bit s;
    longint unsigned mx, my, q, rm, m;
    cx = fclass(x);
    cy = fclass(y);
    s  = x[31] ^ y[31];
    f  = 4'b0000;
    if (cx == 3 || cy == 3 || (cx == 0 && cy == 0) || (cx == 2 && cy == 2)) begin
      r = 32'h7FC00000; f = 4'b1000; return;
    end
    if (cx == 2) begin r = {s, 8'hFF, 23'h0}; return; end
    if (cy == 0) begin r = {s, 8'hFF, 23'h0}; f = 4'b0100; return; end
    if (cx == 0 || cy == 2) begin r = {s, 31'h0}; return; end
    e  = int'(x[30:23]) - int'(y[30:23]) + 127;
    mx = {40'h0, 1'b1, x[22:0]};
    my = {40'h0, 1'b1, y[22:0]};
    q  = (mx << 25) / my;
    rm = (mx << 25) % my;
    if (q < (64'd1 << 25)) begin
      q = q << 1;
      e = e - 1;
    end
    m = q >> 2;
`ifdef FPDIV_ROUND_EN
    if (q[1] && (q[0] || rm != 0 || m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
`endif
    if (e >= 255) begin r = {s, 8'hFF, 23'h0}; f = 4'b0010; end
    else if (e <= 0) begin r = {s, 31'h0}; f = 4'b0001; end
    else r = {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    logic [31:0] x;
    k = $urandom_range(0, 19);
    x = $urandom;
    if (k == 0) x[30:23] = 8'h00;
    else if (k == 1) begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
    else if (k == 2) begin x[30:23] = 8'hFF; x[22] = 1'b1; end
    else begin
      if (k == 3) x[22:0] = 23'h7FFFFF;
      if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) x[30:23] = 8'h01;
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'h0, done}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("flags", {28'h0, flags}, {28'h0, mon_e.flg});
        check("done_cycle", cyc, mon_e.done_at);
        check("busy_window", busy_bad, 0);
        check("result_hold", hold_bad, 0);
        busy_bad = 0;
        hold_bad = 0;
        last_res = mon_e.res;
        last_flg = mon_e.flg;
      end
    end else if (result !== last_res || flags !== last_flg) begin
      hold_bad++;
    end
    if (busy !== (cyc >= busy_from && cyc <= busy_until)) busy_bad++;
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit use_model,
                       input logic [31:0] want_r, input logic [3:0] want_f);
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    if (use_model) model(x, y, r, f);
    else begin r = want_r; f = want_f; end
    lat = (fclass(x) == 1 && fclass(y) == 1) ? 30 : 2;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb.push_back('{r, f, cyc + lat});
    busy_from  = cyc + 1;
    busy_until = cyc + lat;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("completion_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                         input logic [3:0] f);
    issue(x, y, 1'b0, r, f);
    wait_idle();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_flags", {28'h0, flags}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run_one(32'h40580000, 32'h40100000, 32'h3FC00000, 4'b0000);
`ifdef FPDIV_ROUND_EN
    run_one(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);
`else
    run_one(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000);
`endif
    run_one(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100);
    run_one(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_one(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001);

    // Second start while busy must be ignored
    issue(32'h40580000, 32'h40100000, 1'b0, 32'h3FC00000, 4'b0000);
    repeat (3) @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    run_one(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010);

    // Reset in the middle of an operation
    issue(32'h3F800000, 32'h40400000, 1'b0, 32'h0, 4'b0000);
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_result", result, 32'h0);
    check("abort_flags", {28'h0, flags}, 32'h0);
    sb.delete();
    busy_until = -1;
    last_res   = '0;
    last_flg   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_one(32'h40580000, 32'h40100000, 32'h3FC00000, 4'b0000);

    for (int i = 0; i < 150; i++) begin
      issue(rand_op(), rand_op(), 1'b1, 32'h0, 4'b0000);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("busy_tail", busy_bad, 0);
    check("hold_tail", hold_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/floating_point_divider.md
FLOATING_POINT_DIVIDER -- requirements
Module: floating_point_divider

Interface
REQ-001 Parameters SHALL be:
  - WIDTH, 32, total word width
  - EXP_WIDTH, 8, exponent width
  - MANT_WIDTH, 23, stored mantissa width
REQ-002 Ports SHALL be:
  - clk  input  1  single clock, rising edge
  - reset  input  1  asynchronous, active-low reset (asserted at 0)
  - start  input  1  request; sampled only in IDLE
  - a  input  WIDTH  IEEE-754 dividend
  - b  input  WIDTH  IEEE-754 divisor
  - busy  output  1  high from start acceptance until the done cycle, inclusive
  - done  output  1  single-cycle pulse, result and flags valid
  - result  output  WIDTH  quotient a/b
  - flags  output  4  {invalid, div_by_zero, overflow, underflow}, valid with done

Function
REQ-003 FSM states SHALL be IDLE, UNPACK, DIVIDE, NORMALIZE, ROUND, DONE.
REQ-004 Transitions SHALL be:
  - IDLE->UNPACK on start; a and b are captured on that same edge.
  - UNPACK->DONE if the operands are a special case; otherwise UNPACK->DIVIDE.
  - DIVIDE SHALL run exactly MANT_WIDTH+3 (26) restoring iterations, then go to NORMALIZE.
  - NORMALIZE->ROUND->DONE->IDLE.
REQ-005 Latency, counted from the edge that samples start:
  - normal path: done is high in cycle MANT_WIDTH+7 (30);
  - special path: done is high in cycle 2.
REQ-006 start SHALL be ignored while busy=1; a and b MAY change after capture without effect.
REQ-007 Arithmetic:
  - sign = sign(a) XOR sign(b);
  - exponent = exp(a) - exp(b) + 127, computed at EXP_WIDTH+2 signed bits;
  - quotient = 24-bit hidden-one mantissa division producing 24 quotient bits plus guard and round bits, with sticky = nonzero remainder.
REQ-008 NORMALIZE SHALL shift the quotient left by one and decrement the exponent when the quotient MSB is 0.
REQ-009 Special cases, where denormal inputs are treated as zero:
  - any NaN operand, 0/0, or inf/inf -> 0x7FC00000, invalid=1;
  - finite nonzero / 0 -> signed inf, div_by_zero=1;
  - inf/finite -> signed inf;
  - 0/nonzero or finite/inf -> signed zero.
REQ-010 Range handling:
  - biased exponent >= 255 after rounding -> signed inf, overflow=1;
  - biased exponent <= 0 -> signed zero (flush to zero, no denormal output), underflow=1.
REQ-011 result and flags SHALL hold their values from done until the next done; done SHALL be low in every other cycle.

Reset
REQ-012 While reset=0, asynchronously:
  - state=IDLE;
  - busy=0, done=0, result=0, flags=0;
  - the iteration counter and working registers are cleared.
REQ-013 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release is handled normally.

Configuration
REQ-014 Macro FPDIV_ROUND_EN:
  - defined: ROUND applies round-to-nearest-even using guard, round and sticky, and a mantissa carry-out increments the exponent;
  - undefined: ROUND truncates.
  - The ROUND state and the latency are identical in both builds.

Structure
REQ-015 Shared package fp_pkg SHALL hold:
  - WIDTH, EXP_WIDTH, MANT_WIDTH and BIAS constants;
  - QNAN (0x7FC00000);
  - fp_class_t enum {ZERO, NORMAL, INF, NAN};
  - fp_flags_t packed struct;
  - the divider state enum.
REQ-016 One combinational sub-module, fp_classify, SHALL map an operand to {sign, exp, mant_with_hidden, fp_class_t}; it SHALL be instantiated twice.

Verification
REQ-017 0x40580000 / 0x40100000 (3.375/2.25) -> result 0x3FC00000, flags 0, done exactly 30 cycles after start, busy high throughout.
REQ-018 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with FPDIV_ROUND_EN; 0x3EAAAAAA without it.
REQ-019 Special-case results, each with done at cycle 2:
  - 0xBF800000 / 0x00000000 -> 0xFF800000, div_by_zero=1;
  - 0x00000000 / 0x00000000 -> 0x7FC00000, invalid=1.
REQ-020 Range cases:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow=1;
  - 0x00800000 / 0x40000000 -> 0x00000000, underflow=1.
REQ-021 Busy and reset behaviour:
  - start pulsed again at cycle 5 of an operation -> ignored; one done only, with the first operands' result.
  - reset=0 at cycle 10 -> all outputs 0 immediately and no done; a new start after release gives the correct result.
